// File: rtl/de4_qsys_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : de4_qsys_pio_pkg
// Description : Shared register map and edge-select encodings for the DE4
//               QSYS PIO peripherals.
// Revision    : 1.0 - initial release
// ============================================================================
package de4_qsys_pio_pkg;

    // Avalon-MM register offsets (word addresses)
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Edge-capture selection
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage
`default_nettype wire

// File: rtl/pio_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : pio_debounce_bit
// Description : One input bit: two-flop synchronizer followed by a counting
//               debouncer. Exposes the accepted level and its next value so
//               the parent can detect edges on the same clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module pio_debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_VALUE     = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    output logic stable,
    output logic stable_next
);

    logic r_sync1;
    logic r_sync2;
    logic r_stable;

    // Two-stage synchronizer for the asynchronous board input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= RESET_VALUE;
            r_sync2 <= RESET_VALUE;
        end else begin
            r_sync1 <= in_bit;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // No filtering: accept the synchronized level every cycle
            assign stable_next = r_sync2;
        end else begin : g_debounce
            localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_cnt_next;
            logic             w_next;

            // Count consecutive disagreeing samples; accept on the last one
            always_comb begin
                w_cnt_next = r_cnt;
                w_next     = r_stable;
                if (r_sync2 == r_stable) begin
                    w_cnt_next = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_next     = r_sync2;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            // Debounce counter register
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= w_cnt_next;
                end
            end

            assign stable_next = w_next;
        end
    endgenerate

    // Accepted (debounced) level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= RESET_VALUE;
        end else begin
            r_stable <= stable_next;
        end
    end

    assign stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/de4_qsys_button_pio.sv
`default_nettype none
// ============================================================================
// Module      : de4_qsys_button_pio
// Description : Avalon-MM input PIO for DE4 push-buttons / DIP switches.
//               Debounced data register, per-bit sticky edge capture with
//               write-1-to-clear, and a masked level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module de4_qsys_button_pio
    import de4_qsys_pio_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_stable_next;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clear;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_cap;
    logic             w_write;
    logic             w_unused;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            pio_debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_VALUE     (RESET_VALUE[gi])
            ) u_debounce (
                .clk         (clk),
                .reset_n     (reset_n),
                .in_bit      (in_port[gi]),
                .stable      (w_stable[gi]),
                .stable_next (w_stable_next[gi])
            );
        end
    endgenerate

    assign w_write  = chipselect & ~write_n;
    // Upper write-data bits beyond WIDTH carry no register state
    assign w_unused = ^writedata;

    // Select which accepted transitions are recorded
    always_comb begin
        w_edge = '0;
        case (EDGE_TYPE)
            EDGE_RISING:  w_edge = ~w_stable & w_stable_next;
            EDGE_FALLING: w_edge = w_stable & ~w_stable_next;
            default:      w_edge = (~w_stable & w_stable_next) | (w_stable & ~w_stable_next);
        endcase
    end

    // Write-1-to-clear pattern for the edge-capture register
    always_comb begin
        w_clear = '0;
        if (w_write && (address == ADDR_EDGECAP)) begin
            w_clear = writedata[WIDTH-1:0];
        end
    end

    // IRQ mask register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_mask <= '0;
        end else if (w_write && (address == ADDR_IRQMASK)) begin
            r_irq_mask <= writedata[WIDTH-1:0];
        end
    end

    // Sticky edge capture; a new edge wins over a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_cap <= '0;
        end else begin
            r_edge_cap <= (r_edge_cap & ~w_clear) | w_edge;
        end
    end

    // Zero-latency read mux, driven from address regardless of chipselect
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata = 32'(w_stable);
            ADDR_IRQMASK: readdata = 32'(r_irq_mask);
            ADDR_EDGECAP: readdata = 32'(r_edge_cap);
            default:      readdata = '0;
        endcase
    end

    assign irq = |(r_edge_cap & r_irq_mask);

endmodule
`default_nettype wire
